// File: rtl/hash160_sched.sv
// Round-robin scheduler sharing one Hash160 core among NUM_REQ requesters, one job in flight.
// Optional BUSY watchdog: define HASH160_SCHED_TIMEOUT_EN to abort hung jobs with rsp_err=1.
module hash160_sched #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*512-1:0]   req_block,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     core_start,
  output logic [511:0]             core_block,
  input  logic                     core_done,
  input  logic [159:0]             core_digest,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [159:0]             rsp_digest,
  output logic                     rsp_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESPOND} state_t;

  state_t          r_state, w_next;
  logic [ID_W-1:0] r_rr_ptr, r_rsp_id;
  logic [511:0]    r_core_block;
  logic [159:0]    r_rsp_digest;

  logic [ID_W-1:0] w_hi, w_lo, w_win, w_ptr_nxt;
  logic            w_hi_any, w_lo_any, w_any;
  logic            w_xfer, w_done, w_tmo, w_hs;
  logic [511:0]    w_blk;

  // Two-pass search: first valid index at or above rr_ptr, else the lowest valid index (wrap).
  always_comb begin
    w_hi_any = 1'b0;
    w_hi     = '0;
    w_lo_any = 1'b0;
    w_lo     = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_lo_any = 1'b1;
        w_lo     = ID_W'(i);
        if (ID_W'(i) >= r_rr_ptr) begin
          w_hi_any = 1'b1;
          w_hi     = ID_W'(i);
        end
      end
    end
  end

  assign w_any = w_lo_any;
  assign w_win = w_hi_any ? w_hi : w_lo;

  always_comb begin
    w_blk = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) w_blk = req_block[i*512 +: 512];
    end
  end

  assign w_xfer    = (r_state == IDLE) && w_any;
  assign w_done    = (r_state == BUSY) && core_done;
  assign w_hs      = (r_state == RESPOND) && rsp_ready;
  assign w_ptr_nxt = (r_rsp_id == ID_W'(NUM_REQ-1)) ? '0 : r_rsp_id + 1'b1;

`ifdef HASH160_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_rsp_err;

  // Counter is zero on the first BUSY cycle; a simultaneous core_done wins over the abort.
  assign w_tmo = (r_state == BUSY) && !core_done &&
                 (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst)                    r_tmo_cnt <= '0;
    else if (r_state == LAUNCH) r_tmo_cnt <= '0;
    else if (r_state == BUSY)   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_rsp_err <= 1'b0;
    else if (w_done) r_rsp_err <= 1'b0;
    else if (w_tmo)  r_rsp_err <= 1'b1;
  end

  assign rsp_err = r_rsp_err;
`else
  logic w_unused_tmo;

  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign rsp_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = LAUNCH;
      LAUNCH:  w_next = BUSY;
      BUSY:    if (w_done || w_tmo) w_next = RESPOND;
      RESPOND: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_rsp_id     <= '0;
      r_core_block <= '0;
      r_rsp_digest <= '0;
    end else begin
      if (w_xfer) begin
        r_core_block <= w_blk;
        r_rsp_id     <= w_win;
      end
      if (w_done)      r_rsp_digest <= core_digest;
      else if (w_tmo)  r_rsp_digest <= '0;
      if (w_hs)        r_rr_ptr     <= w_ptr_nxt;
    end
  end

  // Grant is suppressed while reset is held so nothing looks transferred during reset.
  assign req_ready  = (r_state == IDLE && !rst && w_any) ? (NUM_REQ'(1) << w_win) : '0;
  assign core_start = (r_state == LAUNCH);
  assign core_block = r_core_block;
  assign rsp_valid  = (r_state == RESPOND);
  assign rsp_id     = r_rsp_id;
  assign rsp_digest = r_rsp_digest;

endmodule
